// File: rtl/manchester_xnor_decoder.sv
// -----------------------------------------------------------------------------
// manchester_xnor_decoder
//
// Receiver for an XNOR-encoded Manchester line (line = bit_clock XNOR data):
// every bit shows its true value in the first half-bit and its complement in
// the second, so a falling mid-bit transition decodes as 1 and a rising one
// as 0. The line is oversampled with clk, the decoder locks to the mid-bit
// transitions and reassembles words MSB-first into a one-entry valid/ready
// output register.
//
// Parameters
//    OVS    clk samples per bit period (even, >= 4)
//    WIDTH  data bits per frame
//
// Ports
//    clk         system clock, all state on the rising edge
//    rst_n       asynchronous active-low reset
//    line_in     raw Manchester line, asynchronous to clk
//    data_ready  consumer takes data_out when high together with data_valid
//    data_out    last decoded word
//    data_valid  data_out holds an unconsumed word
//    frame_err   one-cycle pulse: frame aborted on a missing mid-bit edge
//    overrun     one-cycle pulse: completed word dropped, register was full
//    parity_err  one-cycle pulse: parity mismatch, word dropped
//
// Build option
//    MANCH_PARITY_EN  frame carries an even-parity bit after the data bits;
//                     undefined: frame is WIDTH bits and parity_err stays 0
// -----------------------------------------------------------------------------
module manchester_xnor_decoder #(
   parameter int OVS   = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             line_in,
   input  logic             data_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             frame_err,
   output logic             overrun,
   output logic             parity_err
);

`ifdef MANCH_PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int CNT_MAX   = (3 * OVS) / 2;
   localparam int WIN_LO    = (3 * OVS) / 4;
   localparam int IDLE_NEED = 2 * OVS;
   localparam int CW        = $clog2(CNT_MAX + 1);
   localparam int EW        = CW + 1;
   localparam int IW        = $clog2(IDLE_NEED + 1);
   localparam int BW        = $clog2(NBITS + 1);

   localparam logic [CW-1:0] CNT_MAX_V = CW'(CNT_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RECV  = 2'd2
   } state_t;

`ifdef MANCH_PARITY_EN
   // Odd number of ones across data plus parity bit means the even-parity check failed.
   function automatic logic parity_bad(input logic [NBITS-1:0] v);
      return ^v;
   endfunction
`endif

   logic             sync1_r;
   logic             sync2_r;
   logic             prev_r;
   state_t           state_r;
   logic [CW-1:0]    cnt_r;
   logic [IW-1:0]    idle_cnt_r;
   logic [BW-1:0]    bitcnt_r;
   logic [NBITS-1:0] sr_r;

   logic             edge_s;
   logic             fall_s;
   logic [EW-1:0]    elapsed_s;
   logic             in_win_s;
   logic             last_bit_s;
   logic [NBITS-1:0] sr_next_s;
   logic [WIDTH-1:0] word_s;
   logic             par_bad_s;

   // Two-flop synchronizer plus previous-sample register for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         prev_r  <= 1'b0;
      end else begin
         sync1_r <= line_in;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   // Edge classification, acceptance window and the word being completed.
   always_comb begin
      edge_s     = sync2_r ^ prev_r;
      fall_s     = prev_r & ~sync2_r;
      // cnt_r was cleared on the clock that accepted the previous edge, so
      // the sample distance to that edge is one more than the register.
      elapsed_s  = {1'b0, cnt_r} + {{CW{1'b0}}, 1'b1};
      in_win_s   = (elapsed_s >= EW'(WIN_LO)) && (elapsed_s < EW'(CNT_MAX));
      last_bit_s = (bitcnt_r == BW'(NBITS - 1));
      sr_next_s  = {sr_r[NBITS-2:0], fall_s};
`ifdef MANCH_PARITY_EN
      word_s     = sr_next_s[NBITS-1:1];
      par_bad_s  = parity_bad(sr_next_s);
`else
      word_s     = sr_next_s;
      par_bad_s  = 1'b0;
`endif
   end

   // Receive FSM with registered output register and error pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         cnt_r      <= {CW{1'b0}};
         idle_cnt_r <= {IW{1'b0}};
         bitcnt_r   <= {BW{1'b0}};
         sr_r       <= {NBITS{1'b0}};
         data_out   <= {WIDTH{1'b0}};
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         parity_err <= 1'b0;
         // Consumption; a load later in this block takes precedence.
         if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
         case (state_r)
            IDLE: begin
               cnt_r <= {CW{1'b0}};
               if (!sync2_r) begin
                  idle_cnt_r <= {IW{1'b0}};
               end else if (idle_cnt_r == IW'(IDLE_NEED - 1)) begin
                  idle_cnt_r <= {IW{1'b0}};
                  state_r    <= ARMED;
               end else begin
                  idle_cnt_r <= idle_cnt_r + IW'(1);
               end
            end
            ARMED: begin
               if (edge_s) begin
                  if (fall_s) begin
                     state_r  <= RECV;
                     cnt_r    <= {CW{1'b0}};
                     bitcnt_r <= {BW{1'b0}};
                  end else begin
                     state_r <= IDLE;
                  end
               end
            end
            RECV: begin
               if (edge_s && in_win_s) begin
                  sr_r     <= sr_next_s;
                  bitcnt_r <= bitcnt_r + BW'(1);
                  cnt_r    <= {CW{1'b0}};
                  if (last_bit_s) begin
                     state_r    <= IDLE;
                     idle_cnt_r <= {IW{1'b0}};
                     if (par_bad_s) begin
                        parity_err <= 1'b1;
                     end else if (data_valid && !data_ready) begin
                        overrun <= 1'b1;
                     end else begin
                        data_out   <= word_s;
                        data_valid <= 1'b1;
                     end
                  end
               end else if (cnt_r == CNT_MAX_V) begin
                  // No mid-bit edge within 1.5 bit periods: abort the frame.
                  frame_err  <= 1'b1;
                  state_r    <= IDLE;
                  idle_cnt_r <= {IW{1'b0}};
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_manchester_xnor_decoder.sv
// -----------------------------------------------------------------------------
// tb_manchester_xnor_decoder
//
// Self-checking bench: builds oversampled XNOR-Manchester waveforms (one line
// sample per clk), pushes the expected word into a scoreboard queue when a
// frame is driven and pops it when data_valid rises. Line and inputs change
// on the falling clock edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_manchester_xnor_decoder;
   localparam int OVS   = 8;
   localparam int WIDTH = 8;
   localparam int HALF  = OVS / 2;
`ifdef MANCH_PARITY_EN
   localparam int NB = WIDTH + 1;
`else
   localparam int NB = WIDTH;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             line_in = 1'b1;
   logic             data_ready = 1'b0;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             frame_err;
   logic             overrun;
   logic             parity_err;

   manchester_xnor_decoder #(.OVS(OVS), .WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .line_in    (line_in),
      .data_ready (data_ready),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   int               tests = 0;
   int               fails = 0;
   logic [WIDTH-1:0] exp_q[$];

   // Observations of the most recent send_frame call (sample indices).
   int               mid_pos;
   int               dv_rise, fe_rise, ov_rise, pe_rise;
   int               fe_n, ov_n, pe_n;
   logic [WIDTH-1:0] got_word;

   // Mid-bit offsets for the jitter frame; adjacent differences stay within 2.
   int offs[10] = '{0, 2, 1, -1, 0, 2, 0, -2, 0, 0};

   // Drive 20 idle samples, the start bit plus nsend-1 further bits, then tail idle samples.
   task automatic send_frame(input logic [WIDTH-1:0] data, input int nsend,
                             input bit bad_par, input bit jit, input int tail);
      logic bits[$];
      logic wave[$];
      int   glitch[$];
      logic prev_dv;
      bits.push_back(1'b1);
      for (int i = 0; i < WIDTH; i++) bits.push_back(data[WIDTH-1-i]);
`ifdef MANCH_PARITY_EN
      bits.push_back((^data) ^ bad_par);
`endif
      for (int i = 0; i < 20; i++) wave.push_back(1'b1);
      mid_pos = -1;
      for (int i = 0; i < nsend; i++) begin
         int o;
         o = jit ? offs[i] : 0;
         for (int k = 0; k < HALF + o; k++) wave.push_back(bits[i]);
         mid_pos = wave.size();
         for (int k = 0; k < HALF - o; k++) wave.push_back(~bits[i]);
         // One-sample glitch two samples after the mid edge where no boundary edge sits.
         if (jit && i < nsend - 1 && bits[i] != bits[i+1]) glitch.push_back(mid_pos + 2);
      end
      foreach (glitch[g]) wave[glitch[g]] = ~wave[glitch[g]];
      for (int i = 0; i < tail; i++) wave.push_back(1'b1);
      dv_rise = -1; fe_rise = -1; ov_rise = -1; pe_rise = -1;
      fe_n = 0; ov_n = 0; pe_n = 0;
      prev_dv = data_valid;
      for (int k = 0; k < wave.size(); k++) begin
         @(negedge clk);
         if (data_valid && !prev_dv && dv_rise < 0) begin
            dv_rise  = k;
            got_word = data_out;
         end
         prev_dv = data_valid;
         if (frame_err)  begin fe_n++; if (fe_rise < 0) fe_rise = k; end
         if (overrun)    begin ov_n++; if (ov_rise < 0) ov_rise = k; end
         if (parity_err) begin pe_n++; if (pe_rise < 0) pe_rise = k; end
         line_in = wave[k];
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; line_in = 1'b1; data_ready = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({data_out, data_valid, frame_err, overrun, parity_err} !== {(WIDTH+4){1'b0}}) begin
         fails++;
         $display("FAIL reset_outputs: got dout=%h dv=%b fe=%b ov=%b pe=%b, want all 0",
                  data_out, data_valid, frame_err, overrun, parity_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      logic [WIDTH-1:0] e;
      data_ready = 1'b0;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, NB + 1, 1'b0, 1'b0, 8);
      // Line change at negedge m: sync1, sync2, then the FSM loads on the 3rd rising edge.
      tests++;
      if (dv_rise !== mid_pos + 3) begin
         fails++; $display("FAIL basic_latency: got %0d want %0d", dv_rise, mid_pos + 3);
      end
      tests++;
      if (dv_rise < 0) begin
         fails++; $display("FAIL basic_word: got no data_valid want %h", exp_q[0]);
      end else begin
         e = exp_q.pop_front();
         if (got_word !== e) begin fails++; $display("FAIL basic_word: got %h want %h", got_word, e); end
      end
      tests++;
      if (fe_n + ov_n + pe_n !== 0) begin
         fails++; $display("FAIL basic_errors: got fe=%0d ov=%0d pe=%0d want 0", fe_n, ov_n, pe_n);
      end
      data_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (data_valid !== 1'b0) begin fails++; $display("FAIL basic_consume: got dv=%b want 0", data_valid); end
      data_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [WIDTH-1:0] e;
      data_ready = 1'b0;
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, NB + 1, 1'b0, 1'b0, 8);
      tests++;
      if (dv_rise < 0) begin
         fails++; $display("FAIL b2b_first: got no data_valid want %h", exp_q[0]);
      end else begin
         e = exp_q.pop_front();
         if (got_word !== e) begin fails++; $display("FAIL b2b_first: got %h want %h", got_word, e); end
      end
      send_frame(8'h81, NB + 1, 1'b0, 1'b0, 8);
      tests++;
      if (ov_n !== 1 || ov_rise !== mid_pos + 3) begin
         fails++; $display("FAIL b2b_overrun: got %0d cycles at %0d want 1 at %0d", ov_n, ov_rise, mid_pos + 3);
      end
      tests++;
      if (data_out !== 8'h3C || data_valid !== 1'b1) begin
         fails++; $display("FAIL b2b_kept: got %h dv=%b want 3c dv=1", data_out, data_valid);
      end
      data_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (data_valid !== 1'b0) begin fails++; $display("FAIL b2b_consume: got dv=%b want 0", data_valid); end
      data_ready = 1'b0;
   endtask

   task automatic test_timeout;
      logic [WIDTH-1:0] e;
      data_ready = 1'b0;
      send_frame(8'hA0, 4, 1'b0, 1'b0, 40);
      // Accepted on edge m+3 (cnt=0), cnt saturates 12 clocks later, pulse one clock after.
      tests++;
      if (fe_n !== 1 || fe_rise !== mid_pos + 16) begin
         fails++; $display("FAIL timeout_frame_err: got %0d cycles at %0d want 1 at %0d", fe_n, fe_rise, mid_pos + 16);
      end
      tests++;
      if (dv_rise !== -1) begin fails++; $display("FAIL timeout_no_valid: got rise at %0d want none", dv_rise); end
      exp_q.push_back(8'h11);
      send_frame(8'h11, NB + 1, 1'b0, 1'b0, 8);
      tests++;
      if (dv_rise < 0) begin
         fails++; $display("FAIL timeout_next: got no data_valid want %h", exp_q[0]);
      end else begin
         e = exp_q.pop_front();
         if (got_word !== e) begin fails++; $display("FAIL timeout_next: got %h want %h", got_word, e); end
      end
      data_ready = 1'b1; @(negedge clk); data_ready = 1'b0;
   endtask

   task automatic test_jitter;
      logic [WIDTH-1:0] e;
      data_ready = 1'b0;
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, NB + 1, 1'b0, 1'b1, 8);
      tests++;
      if (dv_rise < 0) begin
         fails++; $display("FAIL jitter_word: got no data_valid want %h", exp_q[0]);
      end else begin
         e = exp_q.pop_front();
         if (got_word !== e) begin fails++; $display("FAIL jitter_word: got %h want %h", got_word, e); end
      end
      tests++;
      if (fe_n + ov_n + pe_n !== 0) begin
         fails++; $display("FAIL jitter_errors: got fe=%0d ov=%0d pe=%0d want 0", fe_n, ov_n, pe_n);
      end
      data_ready = 1'b1; @(negedge clk); data_ready = 1'b0;
   endtask

   task automatic test_reset_midframe;
      logic [WIDTH-1:0] e;
      data_ready = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, NB + 1, 1'b0, 1'b0, 8);
      tests++;
      if (dv_rise < 0) begin
         fails++; $display("FAIL rst_pre_word: got no data_valid want %h", exp_q[0]);
      end else begin
         e = exp_q.pop_front();
         if (got_word !== e) begin fails++; $display("FAIL rst_pre_word: got %h want %h", got_word, e); end
      end
      send_frame(8'hC3, 4, 1'b0, 1'b0, 0);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({data_out, data_valid, frame_err, overrun, parity_err} !== {(WIDTH+4){1'b0}}) begin
         fails++;
         $display("FAIL rst_async: got dout=%h dv=%b fe=%b ov=%b pe=%b, want all 0",
                  data_out, data_valid, frame_err, overrun, parity_err);
      end
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(8'hC3);
      send_frame(8'hC3, NB + 1, 1'b0, 1'b0, 8);
      tests++;
      if (dv_rise < 0) begin
         fails++; $display("FAIL rst_next_word: got no data_valid want %h", exp_q[0]);
      end else begin
         e = exp_q.pop_front();
         if (got_word !== e) begin fails++; $display("FAIL rst_next_word: got %h want %h", got_word, e); end
      end
      data_ready = 1'b1; @(negedge clk); data_ready = 1'b0;
   endtask

`ifdef MANCH_PARITY_EN
   task automatic test_parity;
      logic [WIDTH-1:0] e;
      data_ready = 1'b0;
      send_frame(8'hF0, NB + 1, 1'b1, 1'b0, 8);
      tests++;
      if (pe_n !== 1 || pe_rise !== mid_pos + 3) begin
         fails++; $display("FAIL parity_err_pulse: got %0d cycles at %0d want 1 at %0d", pe_n, pe_rise, mid_pos + 3);
      end
      tests++;
      if (dv_rise !== -1 || data_valid !== 1'b0) begin
         fails++; $display("FAIL parity_dropped: got rise %0d dv=%b want none dv=0", dv_rise, data_valid);
      end
      exp_q.push_back(8'hF0);
      send_frame(8'hF0, NB + 1, 1'b0, 1'b0, 8);
      tests++;
      if (dv_rise < 0 || pe_n !== 0) begin
         fails++; $display("FAIL parity_good: got rise %0d pe=%0d want load and pe=0", dv_rise, pe_n);
      end else begin
         e = exp_q.pop_front();
         if (got_word !== e) begin fails++; $display("FAIL parity_good: got %h want %h", got_word, e); end
      end
      data_ready = 1'b1; @(negedge clk); data_ready = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_timeout();
      test_jitter();
      test_reset_midframe();
`ifdef MANCH_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
